// File: rtl/ins_fetch_split.sv
// ins_fetch_split: PC, ROM addressing and opcode/immediate capture ahead of the control FSM (optional ILLEGAL_OP_EN trap)
module ins_fetch_split #(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            ins_load,
    input  logic            pc_load,
    input  logic            pc_inc,
    output logic [PC_W-1:0] rom_addr,
    input  logic [7:0]      rom_data,
    output logic [3:0]      opcode,
    output logic [1:0]      op1_sel,
    output logic [1:0]      op2_sel,
    output logic [7:0]      imm,
    output logic            ins_valid,
    output logic            imm_valid,
    output logic            two_byte,
    output logic [PC_W-1:0] pc_hold,
    output logic            illegal_op
);
    typedef enum logic {S_OP, S_IMM} state_t;
`ifdef ILLEGAL_OP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_hold_q, pc_hold_d;
    logic [7:0]      ir_q, ir_d, imm_q, imm_d;
    logic            ins_valid_q, ins_valid_d, imm_valid_q, imm_valid_d, illegal_q, illegal_d;
    logic            bad_op;
    assign bad_op     = ILL_EN && rom_data[7:5] == 3'b111;
    assign rom_addr   = pc_q;
    assign opcode     = ir_q[7:4];
    assign op1_sel    = ir_q[3:2];
    assign op2_sel    = ir_q[1:0];
    assign imm        = imm_q;
    assign ins_valid  = ins_valid_q;
    assign imm_valid  = imm_valid_q;
    assign two_byte   = ir_q[7:5] == 3'b110;
    assign pc_hold    = pc_hold_q;
    assign illegal_op = illegal_q;
    // Next state: en low abandons any instruction; a latched illegal opcode freezes PC and capture
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_hold_d   = pc_hold_q;
        ir_d        = ir_q;
        imm_d       = imm_q;
        ins_valid_d = ins_valid_q;
        imm_valid_d = imm_valid_q;
        illegal_d   = illegal_q;
        if (!en) begin
            state_d     = S_OP;
            ins_valid_d = 1'b0;
            imm_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end else begin
            if (pc_load) pc_hold_d = pc_q;
            if (pc_inc && !illegal_q) pc_d = pc_q + 1'b1;
            if (ins_load && !illegal_q) begin
                if (state_q == S_OP) begin
                    ir_d        = rom_data;
                    ins_valid_d = 1'b1;
                    imm_valid_d = 1'b0;
                    illegal_d   = bad_op;
                    state_d     = rom_data[7:5] == 3'b110 ? S_IMM : S_OP;
                end else begin
                    imm_d       = rom_data;
                    imm_valid_d = 1'b1;
                    state_d     = S_OP;
                end
            end
        end
    end
    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OP;
            pc_q        <= RST_PC;
            pc_hold_q   <= '0;
            ir_q        <= '0;
            imm_q       <= '0;
            ins_valid_q <= 1'b0;
            imm_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_hold_q   <= pc_hold_d;
            ir_q        <= ir_d;
            imm_q       <= imm_d;
            ins_valid_q <= ins_valid_d;
            imm_valid_q <= imm_valid_d;
            illegal_q   <= illegal_d;
        end
    end
endmodule

// File: tb/tb_ins_fetch_split.sv
// tb_ins_fetch_split: directed scoreboard bench for ins_fetch_split
module tb_ins_fetch_split;
    logic       clk = 0, rst_n = 1, en = 0, ins_load = 0, pc_load = 0, pc_inc = 0;
    logic [7:0] rom_addr, rom_data, imm, pc_hold;
    logic [3:0] opcode;
    logic [1:0] op1_sel, op2_sel;
    logic       ins_valid, imm_valid, two_byte, illegal_op;
    logic [7:0] rom [256];
    int         n_vec = 0, n_err = 0;
    string      tq[$];
    logic [31:0] eq[$];
`ifdef ILLEGAL_OP_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    ins_fetch_split dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ins_load(ins_load), .pc_load(pc_load),
        .pc_inc(pc_inc), .rom_addr(rom_addr), .rom_data(rom_data), .opcode(opcode),
        .op1_sel(op1_sel), .op2_sel(op2_sel), .imm(imm), .ins_valid(ins_valid),
        .imm_valid(imm_valid), .two_byte(two_byte), .pc_hold(pc_hold), .illegal_op(illegal_op)
    );

    assign rom_data = rom[rom_addr];
    always #5 clk = ~clk;

    task automatic put(input string t, input logic [31:0] e);
        tq.push_back(t);
        eq.push_back(e);
    endtask

    task automatic got(input logic [31:0] o);
        string       t;
        logic [31:0] e;
        n_vec++;
        if (eq.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: got %0h with no expected value queued", o);
        end else begin
            t = tq.pop_front();
            e = eq.pop_front();
            assert (o === e) else begin
                n_err++;
                $error("FAIL %s: got %0h expected %0h", t, o, e);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic il, input logic pl, input logic pi);
        ins_load = il;
        pc_load  = pl;
        pc_inc   = pi;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[8'h00] = 8'h05;
        rom[8'h03] = 8'hC4;
        rom[8'h04] = 8'h5A;
        rom[8'hFF] = 8'h9A;
        rom[8'h01] = 8'hD0;
        rom[8'h02] = 8'hE0;
        // asynchronous reset asserted mid-cycle
        #3 rst_n = 0;
        put("rst_addr", 0); put("rst_valid", 0); put("rst_opcode", 0); put("rst_imm", 0);
        put("rst_hold", 0); put("rst_illegal", 0); put("rst_imm_valid", 0);
        #1;
        got(rom_addr); got(ins_valid); got(opcode); got(imm);
        got(pc_hold); got(illegal_op); got(imm_valid);
        cyc(); cyc();
        rst_n = 1;
        en = 1;
        // 1-byte fetch at PC 0
        drive(1, 1, 0);
        put("f1_opcode", 4'h0); put("f1_op1", 2'b01); put("f1_op2", 2'b01);
        put("f1_valid", 1); put("f1_two", 0); put("f1_hold", 8'h00);
        cyc();
        got(opcode); got(op1_sel); got(op2_sel); got(ins_valid); got(two_byte); got(pc_hold);
        drive(0, 0, 1);
        put("f1_pc", 8'h01);
        cyc();
        got(rom_addr);
        cyc(); cyc();
        // MVI at PC 3: load, execute, 2byteload, 2byteexecute
        drive(0, 0, 0);
        put("mvi_start_pc", 8'h03);
        got(rom_addr);
        drive(1, 1, 0);
        put("mvi_opcode1", 4'hC); put("mvi_two", 1); put("mvi_immv1", 0);
        cyc();
        got(opcode); got(two_byte); got(imm_valid);
        drive(0, 0, 1); cyc();
        drive(1, 1, 0); cyc();
        drive(0, 0, 1);
        put("mvi_opcode2", 4'hC); put("mvi_op1", 2'b01); put("mvi_op2", 2'b00);
        put("mvi_imm", 8'h5A); put("mvi_immv", 1); put("mvi_pc", 8'h05); put("mvi_hold", 8'h04);
        cyc();
        drive(0, 0, 0);
        got(opcode); got(op1_sel); got(op2_sel); got(imm); got(imm_valid); got(rom_addr); got(pc_hold);
        // run PC up to all-ones, then wrap with all three strobes together
        drive(0, 0, 1);
        repeat (250) cyc();
        drive(0, 0, 0);
        put("wrap_pre_pc", 8'hFF);
        got(rom_addr);
        drive(1, 1, 1);
        put("wrap_opcode", 4'h9); put("wrap_op1", 2'b10); put("wrap_op2", 2'b10);
        put("wrap_hold", 8'hFF); put("wrap_pc", 8'h00); put("wrap_immv", 0);
        cyc();
        got(opcode); got(op1_sel); got(op2_sel); got(pc_hold); got(rom_addr); got(imm_valid);
        // LDA first byte at PC 1, then en drop abandons it
        drive(0, 0, 1); cyc();
        drive(1, 1, 0);
        put("lda_opcode", 4'hD); put("lda_two", 1);
        cyc();
        got(opcode); got(two_byte);
        en = 0;
        drive(1, 1, 1);
        put("endrop_valid", 0); put("endrop_pc", 8'h01); put("endrop_imm", 8'h5A);
        put("endrop_opcode", 4'hD); put("endrop_hold", 8'h01);
        cyc();
        got(ins_valid); got(rom_addr); got(imm); got(opcode); got(pc_hold);
        en = 1;
        rom[8'h01] = 8'h20;
        drive(1, 0, 0);
        put("after_opcode", 4'h2); put("after_immv", 0); put("after_valid", 1); put("after_imm", 8'h5A);
        cyc();
        got(opcode); got(imm_valid); got(ins_valid); got(imm);
        rom[8'h01] = 8'h37;
        put("sop_opcode", 4'h3); put("sop_op1", 2'b01); put("sop_op2", 2'b11);
        cyc();
        got(opcode); got(op1_sel); got(op2_sel);
        // illegal opcode 0xE0 at PC 2
        drive(0, 0, 1); cyc();
        drive(1, 1, 0);
        put("ill_flag", ILL); put("ill_opcode", 4'hE); put("ill_two", 0);
        cyc();
        got(illegal_op); got(opcode); got(two_byte);
        drive(0, 0, 1);
        put("ill_pc", ILL ? 8'h02 : 8'h03);
        cyc();
        got(rom_addr);
        drive(0, 0, 0);
        en = 0;
        put("ill_clear", 0); put("ill_clear_valid", 0);
        cyc();
        got(illegal_op); got(ins_valid);
        en = 1;
        drive(0, 0, 1);
        put("ill_resume_pc", ILL ? 8'h03 : 8'h04);
        cyc();
        drive(0, 0, 0);
        got(rom_addr);
        if (eq.size() != 0) begin
            n_err++;
            $error("FAIL scoreboard_leftover: got %0d entries expected 0", eq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ins_fetch_split.md
Name: ins_fetch_split

Overview:
- Instruction fetch and split stage directly upstream of the CPU control-signal FSM.
- Owns the program counter, drives the instruction ROM address, and captures instruction bytes on the controller's load strobe.
- Splits each instruction into the opcode and register-select fields that the controller decodes.
- Sequences 2-byte instructions (MVI 4'b1100, LDA 4'b1101) so the second byte lands in an immediate register and does not overwrite the opcode.

Parameters:
PC_W, 8, program counter / ROM address width
RST_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  stage enable, shared with the control FSM
ins_load  in  1  capture rom_data this cycle (controller CS_Ins_load)
pc_load  in  1  copy PC into pc_hold (controller CS_PC_load)
pc_inc  in  1  increment PC (controller CS_PC_inc)
rom_addr  out  PC_W  ROM address; equals PC combinationally
rom_data  in  8  ROM byte at rom_addr; combinational ROM, valid in the same cycle
opcode  out  4  IR[7:4], feeds controller CS_opcode
op1_sel  out  2  IR[3:2], operand-1 register select
op2_sel  out  2  IR[1:0], operand-2 register select
imm  out  8  second byte of a 2-byte instruction
ins_valid  out  1  IR holds a captured opcode byte
imm_valid  out  1  imm belongs to the current IR
two_byte  out  1  current opcode is 4'b1100 or 4'b1101
pc_hold  out  PC_W  PC snapshot for the addressing-mode path
illegal_op  out  1  see Optional Feature

Behaviour:
- Reset (rst_n low, asynchronous):
  - PC=RST_PC, IR=0, imm=0, pc_hold=0.
  - ins_valid=0, imm_valid=0, illegal_op=0, FSM=S_OP.
  - Release of reset is synchronous to clk.
- en low, sampled on the clock edge:
  - FSM<=S_OP, ins_valid<=0, imm_valid<=0, illegal_op<=0.
  - PC, IR, imm and pc_hold hold their values.
  - All strobes are ignored.
- PC:
  - pc_inc: PC<=PC+1, modulo 2^PC_W, so all-ones wraps to 0.
  - pc_load: pc_hold<=current PC. When pc_load and pc_inc are asserted together, pc_hold takes the pre-increment value.
- FSM states: S_OP (next ins_load is an opcode byte), S_IMM (next ins_load is an immediate byte).
- In S_OP, on ins_load:
  - IR<=rom_data, ins_valid<=1, imm_valid<=0.
  - If rom_data[7:4] is 1100 or 1101, go to S_IMM; otherwise stay in S_OP.
- In S_IMM, on ins_load:
  - imm<=rom_data, imm_valid<=1, go to S_OP.
  - IR is unchanged.
- ins_load with pc_inc in the same cycle: the byte is captured from the pre-increment address and the PC then increments.
- Latency:
  - The byte at PC appears on opcode/op1_sel/op2_sel/imm one cycle after the ins_load edge.
  - two_byte is combinational from IR.
- Expected controller sequence for a 2-byte instruction:
  - load (ins_load+pc_load) → execute (pc_inc) → 2byteload (ins_load+pc_load) → 2byteexecute (pc_inc).
  - PC advances by 2 in total.
- Reset or en drop while in S_IMM abandons the instruction. The next ins_load is treated as an opcode byte.
- ins_load with en=1 never leaves outputs X; rom_data is captured as-is.

Optional Feature:
- Macro: ILLEGAL_OP_EN
- Defined:
  - An opcode capture with rom_data[7:4] equal to 1110 or 1111 sets illegal_op=1, sticky.
  - While illegal_op=1, pc_inc is ignored (PC freezes) and ins_load is ignored.
  - Cleared only by rst_n low or en low.
- Undefined:
  - illegal_op is tied to 0.
  - 1110/1111 are captured like any 1-byte opcode and the PC advances normally.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → all outputs clear immediately; rom_addr=0x00 with RST_PC=0.
- 1-byte fetch: ROM[0]=0x05; ins_load+pc_load, then pc_inc → opcode=0000, op1_sel=01, op2_sel=01, ins_valid=1, two_byte=0, pc_hold=0x00, PC=0x01.
- MVI: ROM[3]=0xC4, ROM[4]=0x5A, run the 4-step controller sequence from PC=3 → opcode=1100, op1_sel=01, imm=0x5A, imm_valid=1, PC=5; IR still 0xC4 after the second load.
- Wrap and simultaneous strobes: PC=0xFF, ins_load+pc_load+pc_inc in one cycle with ROM[0xFF]=0x9A → IR=0x9A, pc_hold=0xFF, PC=0x00.
- en drop in S_IMM: after the LDA first byte (0xD0), pulse en=0 for 1 cycle, then ins_load with rom_data=0x20 → opcode=0010, imm_valid=0, FSM in S_OP.
- ILLEGAL_OP_EN defined: ROM[2]=0xE0 captured → illegal_op=1; the following pc_inc leaves PC=2; en=0 clears the flag. With the macro undefined, the same stimulus gives illegal_op=0 and PC=3.
